// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin sharing of one UART transmit path among NREQ requesters; optional WAIT timeout under TX_TIMEOUT_EN
module uart_tx_arbiter #(
    parameter int NREQ        = 4,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [8*NREQ-1:0]       req_data,
    output logic [NREQ-1:0]         ack,
    output logic                    trmt,
    output logic [7:0]              resp,
    input  logic                    tx_done,
    output logic                    busy,
    output logic [$clog2(NREQ)-1:0] grant_id,
    output logic                    tx_err
);

    localparam int IDW = $clog2(NREQ);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XMIT = 2'd1,
        WAIT = 2'd2,
        ACK  = 2'd3
    } state_t;

    state_t         r_state;
    state_t         w_next;
    logic [IDW-1:0] r_grant_id;
    logic [IDW-1:0] r_ptr;
    logic [7:0]     r_resp;
    logic           r_tx_done_q;
    logic [IDW-1:0] w_sel;
    logic [IDW-1:0] w_cand;
    logic           w_found;
    logic [7:0]     w_byte;
    logic           w_tx_rise;
    logic           w_timeout;

    // Reject out-of-range parameters at elaboration.
    if (NREQ < 2 || NREQ > 8 || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_param_check
        $error("uart_tx_arbiter: NREQ or TIMEOUT_CYC out of range");
    end

    // Only a fresh rising edge counts as completion, so a tx_done left high
    // by the previous byte cannot complete the current one.
    assign w_tx_rise = tx_done & ~r_tx_done_q;

    // Round-robin search: first set req bit strictly after the pointer, with wrap.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_cand  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_cand = IDW'((int'(r_ptr) + k) % NREQ);
            if (!w_found && req[w_cand]) begin
                w_found = 1'b1;
                w_sel   = w_cand;
            end
        end
    end

    // Byte of the selected requester.
    always_comb begin
        w_byte = 8'h00;
        for (int i = 0; i < NREQ; i++) begin
            if (w_sel == IDW'(i)) begin
                w_byte = req_data[8*i +: 8];
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic and per-state strobes.
    always_comb begin
        w_next = r_state;
        trmt   = 1'b0;
        busy   = 1'b1;
        ack    = '0;
        unique case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (w_found) begin
                    w_next = XMIT;
                end
            end
            XMIT: begin
                trmt   = 1'b1;
                w_next = WAIT;
            end
            WAIT: begin
                if (w_tx_rise || w_timeout) begin
                    w_next = ACK;
                end
            end
            ACK: begin
                ack[r_grant_id] = 1'b1;
                w_next          = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Grant capture, completion edge history and fairness pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_grant_id  <= '0;
            r_resp      <= 8'h00;
            r_ptr       <= IDW'(NREQ - 1);
            r_tx_done_q <= 1'b0;
        end else begin
            if (r_state == IDLE && w_found) begin
                r_grant_id <= w_sel;
                r_resp     <= w_byte;
            end
            // XMIT also samples so a level already high at start is treated as stale.
            if (r_state == XMIT || r_state == WAIT) begin
                r_tx_done_q <= tx_done;
            end
            if (r_state == ACK) begin
                r_ptr <= r_grant_id;
            end
        end
    end

`ifdef TX_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYC - 1);

    logic [15:0] r_wait_cnt;
    logic        r_timeout;

    // WAIT cycle counter and sticky abort flag for the current byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait_cnt <= 16'd0;
            r_timeout  <= 1'b0;
        end else if (r_state == XMIT) begin
            r_wait_cnt <= 16'd0;
            r_timeout  <= 1'b0;
        end else if (r_state == WAIT) begin
            r_wait_cnt <= r_wait_cnt + 16'd1;
            if (w_timeout && !w_tx_rise) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign w_timeout = (r_state == WAIT) && (r_wait_cnt == TIMEOUT_LAST);
    assign tx_err    = (r_state == ACK) && r_timeout;
`else
    assign w_timeout = 1'b0;
    assign tx_err    = 1'b0;
`endif

    assign resp     = r_resp;
    assign grant_id = r_grant_id;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed vector bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  ack;
    logic        trmt;
    logic [7:0]  resp;
    logic        tx_done;
    logic        busy;
    logic [1:0]  grant_id;
    logic        tx_err;

    logic        use_model;
    logic        tbl_txd;
    logic        m_txd;
    logic        m_run;
    int          m_cnt;
    int          m_delay;

    int          n_vec;
    int          n_err;
    int          got_n;
    int          got_trmts;
    logic [3:0]  got_ack;
    logic [7:0]  got_resp;
    logic        got_err;

    typedef struct packed {
        logic [3:0] req;
        logic       txd;
        logic       trmt;
        logic [3:0] ack;
        logic       busy;
        logic [1:0] gid;
        logic [7:0] resp;
    } vec_t;

    vec_t tbl [22];

    uart_tx_arbiter #(.NREQ(4), .TIMEOUT_CYC(50)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_data (req_data),
        .ack      (ack),
        .trmt     (trmt),
        .resp     (resp),
        .tx_done  (tx_done),
        .busy     (busy),
        .grant_id (grant_id),
        .tx_err   (tx_err)
    );

    always #5 clk = ~clk;

    assign tx_done = use_model ? m_txd : tbl_txd;

    // UART stand-in: clears tx_done on trmt, raises it m_delay cycles after the trmt cycle.
    always @(posedge clk) begin
        if (rst) begin
            m_txd <= 1'b0;
            m_run <= 1'b0;
            m_cnt <= 0;
        end else if (trmt) begin
            m_txd <= 1'b0;
            m_run <= (m_delay > 0);
            m_cnt <= m_delay - 1;
        end else if (m_run) begin
            if (m_cnt <= 1) begin
                m_txd <= 1'b1;
                m_run <= 1'b0;
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b1;
        req = 4'b0000;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_trmt(input string name);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (trmt) begin
                seen = 1'b1;
                break;
            end
        end
        check(name, 32'(seen), 32'd1);
    endtask

    // got_n is the number of cycles after the current one until ack, or -1.
    task automatic wait_ack(input int bound);
        got_n     = -1;
        got_trmts = 0;
        got_ack   = 4'b0000;
        got_resp  = 8'h00;
        got_err   = 1'b0;
        for (int k = 1; k <= bound; k++) begin
            @(negedge clk);
            if (trmt) got_trmts++;
            if (ack != 4'b0000) begin
                got_n    = k;
                got_ack  = ack;
                got_resp = resp;
                got_err  = tx_err;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] exp_b_ack  [5];
        logic [7:0] exp_b_resp [5];
        int         cnt;

        n_vec     = 0;
        n_err     = 0;
        rst       = 1'b1;
        req       = 4'b0000;
        req_data  = {8'h13, 8'h12, 8'h11, 8'hA5};
        use_model = 1'b0;
        tbl_txd   = 1'b0;
        m_delay   = -1;

        //            req     txd   trmt  ack      busy  gid   resp
        tbl = '{
            {4'b0001, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, 8'h00},
            {4'b0001, 1'b0, 1'b1, 4'b0000, 1'b1, 2'd0, 8'hA5},
            {4'b0001, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd0, 8'hA5},
            {4'b0001, 1'b1, 1'b0, 4'b0000, 1'b1, 2'd0, 8'hA5},
            {4'b0000, 1'b1, 1'b0, 4'b0001, 1'b1, 2'd0, 8'hA5},
            {4'b1111, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd0, 8'hA5},
            {4'b1111, 1'b1, 1'b1, 4'b0000, 1'b1, 2'd1, 8'h11},
            {4'b1111, 1'b1, 1'b0, 4'b0000, 1'b1, 2'd1, 8'h11},
            {4'b1111, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd1, 8'h11},
            {4'b1111, 1'b1, 1'b0, 4'b0000, 1'b1, 2'd1, 8'h11},
            {4'b1111, 1'b1, 1'b0, 4'b0010, 1'b1, 2'd1, 8'h11},
            {4'b1111, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd1, 8'h11},
            {4'b1011, 1'b0, 1'b1, 4'b0000, 1'b1, 2'd2, 8'h12},
            {4'b1011, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd2, 8'h12},
            {4'b1011, 1'b1, 1'b0, 4'b0000, 1'b1, 2'd2, 8'h12},
            {4'b1011, 1'b1, 1'b0, 4'b0100, 1'b1, 2'd2, 8'h12},
            {4'b1011, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd2, 8'h12},
            {4'b1011, 1'b0, 1'b1, 4'b0000, 1'b1, 2'd3, 8'h13},
            {4'b1011, 1'b1, 1'b0, 4'b0000, 1'b1, 2'd3, 8'h13},
            {4'b1011, 1'b1, 1'b0, 4'b1000, 1'b1, 2'd3, 8'h13},
            {4'b1011, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd3, 8'h13},
            {4'b0000, 1'b1, 1'b1, 4'b0000, 1'b1, 2'd0, 8'hA5}
        };

        exp_b_ack  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        exp_b_resp = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};

        // Table: each row's outputs are those seen in the cycle its inputs are applied.
        do_reset();
        for (int i = 0; i < 22; i++) begin
            tick();
            req     = tbl[i].req;
            tbl_txd = tbl[i].txd;
            @(negedge clk);
            check($sformatf("tbl_row%0d", i),
                  32'({trmt, ack, busy, grant_id, resp, tx_err}),
                  32'({tbl[i].trmt, tbl[i].ack, tbl[i].busy, tbl[i].gid, tbl[i].resp, 1'b0}));
        end

        // Single byte, UART completes 20 cycles after trmt.
        use_model = 1'b1;
        m_delay   = 20;
        req_data  = {8'h13, 8'h12, 8'h11, 8'hA5};
        do_reset();
        tick();
        req = 4'b0001;
        @(negedge clk);
        check("A_no_trmt_at_req", 32'({trmt, busy}), 32'd0);
        @(negedge clk);
        check("A_trmt", 32'({trmt, grant_id, resp}), 32'({1'b1, 2'd0, 8'hA5}));
        wait_ack(100);
        check("A_ack_latency", 32'(got_n), 32'd21);
        check("A_ack", 32'({got_ack, got_resp, got_err}), 32'({4'b0001, 8'hA5, 1'b0}));
        check("A_one_trmt", 32'(got_trmts), 32'd0);
        tick();
        req = 4'b0000;
        @(negedge clk);
        check("A_idle_after", 32'({busy, trmt}), 32'd0);

        // All four requesting: strict rotation 0,1,2,3,0.
        m_delay  = 10;
        req_data = {8'h13, 8'h12, 8'h11, 8'h10};
        do_reset();
        tick();
        req = 4'b1111;
        cnt = 0;
        for (int b = 0; b < 5; b++) begin
            wait_ack(100);
            cnt += got_trmts;
            check($sformatf("B_ack%0d", b), 32'({got_ack, got_resp}), 32'({exp_b_ack[b], exp_b_resp[b]}));
            check($sformatf("B_trmts%0d", b), 32'(cnt), 32'(b + 1));
        end
        tick();
        req = 4'b0000;

        // req[2] dropped after grant still completes; 1-cycle req[1] pulse while busy is ignored.
        m_delay = 8;
        do_reset();
        tick();
        req = 4'b0100;
        wait_trmt("D_trmt");
        check("D_grant", 32'({grant_id, resp}), 32'({2'd2, 8'h12}));
        tick();
        req = 4'b0000;
        tick();
        req = 4'b0010;
        tick();
        req = 4'b0000;
        wait_ack(50);
        check("D_ack_dropped", 32'({got_ack, got_trmts[3:0]}), 32'({4'b0100, 4'd0}));
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (trmt) cnt++;
            if (ack != 4'b0000) cnt++;
        end
        check("D_pulse_not_granted", 32'(cnt), 32'd0);
        check("D_idle", 32'(busy), 32'd0);

        // Reset while waiting: outputs return to reset values, no ack, requester 0 next.
        m_delay = -1;
        do_reset();
        tick();
        req = 4'b0100;
        wait_trmt("E_trmt");
        repeat (3) @(negedge clk);
        tick();
        rst = 1'b1;
        tick();
        rst     = 1'b0;
        req     = 4'b0101;
        m_delay = 5;
        @(negedge clk);
        check("E_reset_outputs", 32'({trmt, ack, busy, grant_id, resp, tx_err}), 32'd0);
        @(negedge clk);
        check("E_regrant_req0", 32'({trmt, grant_id, resp}), 32'({1'b1, 2'd0, 8'h10}));
        wait_ack(30);
        check("E_ack", 32'(got_ack), 32'(4'b0001));
        tick();
        req = 4'b0000;

        // UART never completes.
        m_delay = -1;
        do_reset();
        tick();
        req = 4'b0001;
        wait_trmt("F_trmt");
        wait_ack(300);
`ifdef TX_TIMEOUT_EN
        check("F_timeout_latency", 32'(got_n), 32'd51);
        check("F_timeout_ack", 32'({got_ack, got_err}), 32'({4'b0001, 1'b1}));
`else
        check("F_no_ack", 32'(got_n), 32'hFFFF_FFFF);
        check("F_stuck", 32'({busy, tx_err}), 32'({1'b1, 1'b0}));
`endif
        do_reset();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
